// File: rtl/vending_fsm_param_if.sv
// Front-panel / dispenser bus of the parametrised vending controller.
//   master : panel + dispenser side, drives select, coin, cancel, vend_ack
//   slave  : controller side, drives product_sel, credit, vend_req,
//            change_valid, change_amt, coin_reject, busy, vend_count
interface vending_fsm_param_if #(
  parameter int unsigned NUM_PROD = 3,
  parameter int unsigned NUM_COIN = 3,
  parameter int unsigned CREDIT_W = 8,
  parameter int unsigned CNT_W    = 16
);
  logic [NUM_PROD-1:0] select;
  logic [NUM_COIN-1:0] coin;
  logic                cancel;
  logic                vend_ack;
  logic [NUM_PROD-1:0] product_sel;
  logic [CREDIT_W-1:0] credit;
  logic                vend_req;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amt;
  logic                coin_reject;
  logic                busy;
  logic [CNT_W-1:0]    vend_count;

  modport master (
    output select, coin, cancel, vend_ack,
    input  product_sel, credit, vend_req, change_valid, change_amt,
           coin_reject, busy, vend_count
  );

  modport slave (
    input  select, coin, cancel, vend_ack,
    output product_sel, credit, vend_req, change_valid, change_amt,
           coin_reject, busy, vend_count
  );
endinterface

// File: rtl/vending_fsm_param.sv
// Parametrised vending controller: product selection, coin accumulation,
// cancel/refund, inactivity timeout and a req/ack dispenser handshake.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high
//   bus   - vending_fsm_param_if.slave: select/coin/cancel/vend_ack in,
//           product_sel/credit/vend_req/change_valid/change_amt/
//           coin_reject/busy/vend_count out (all outputs registered)
module vending_fsm_param #(
  parameter int unsigned                 NUM_PROD    = 3,
  parameter int unsigned                 NUM_COIN    = 3,
  parameter int unsigned                 CREDIT_W    = 8,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES     = {8'd100, 8'd75, 8'd50},
  parameter logic [NUM_COIN*CREDIT_W-1:0] COIN_VALS  = {8'd100, 8'd50, 8'd25},
  parameter int unsigned                 TIMEOUT_CYC = 1000,
  parameter int unsigned                 CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  vending_fsm_param_if.slave  bus
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECTED,
    S_DISPENSE,
    S_CHANGE
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_PROD-1:0] product_sel_q, product_sel_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                vend_req_q, vend_req_d;
  logic                change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
  logic                coin_reject_q, coin_reject_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    vend_count_q, vend_count_d;

  logic                sel_valid;
  logic [NUM_PROD-1:0] sel_onehot;
  logic                coin_valid;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W:0]   sum;
  logic [TMR_W-1:0]    timer_inc;

  // Lowest set select bit wins; the rest are dropped silently.
  always_comb begin
    sel_valid  = 1'b0;
    sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_PROD; i++) begin
      if (bus.select[i] && !sel_valid) begin
        sel_valid     = 1'b1;
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Lowest set coin bit wins; the rest are dropped silently.
  always_comb begin
    coin_valid = 1'b0;
    coin_val   = '0;
    for (int unsigned j = 0; j < NUM_COIN; j++) begin
      if (bus.coin[j] && !coin_valid) begin
        coin_valid = 1'b1;
        coin_val   = COIN_VALS[j*CREDIT_W +: CREDIT_W];
      end
    end
  end

  always_comb begin
    price = '0;
    for (int unsigned i = 0; i < NUM_PROD; i++) begin
      if (product_sel_q[i]) price = PRICES[i*CREDIT_W +: CREDIT_W];
    end
  end

  // One extra bit so an overflowing coin can be detected and refused.
  assign sum       = {1'b0, credit_q} + {1'b0, coin_val};
  assign timer_inc = timer_q + TMR_W'(1);

  always_comb begin
    state_d        = state_q;
    product_sel_d  = product_sel_q;
    credit_d       = credit_q;
    timer_d        = timer_q;
    vend_req_d     = vend_req_q;
    change_valid_d = 1'b0;
    change_amt_d   = change_amt_q;
    coin_reject_d  = 1'b0;
    vend_count_d   = vend_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          state_d       = S_SELECTED;
          product_sel_d = sel_onehot;
          credit_d      = '0;
          timer_d       = '0;
        end else begin
          coin_reject_d = coin_valid;
        end
      end

      S_SELECTED: begin
        if (bus.cancel) begin
          coin_reject_d  = coin_valid;
          state_d        = S_CHANGE;
          change_valid_d = 1'b1;
          change_amt_d   = credit_q;
        end else if (coin_valid && !sum[CREDIT_W]) begin
          credit_d = sum[CREDIT_W-1:0];
          if (sum >= {1'b0, price}) begin
            state_d      = S_DISPENSE;
            change_amt_d = sum[CREDIT_W-1:0] - price;
            vend_req_d   = 1'b1;
          end else begin
            timer_d = '0;
          end
        end else begin
          // An overflowing coin is refused and does not count as activity.
          coin_reject_d = coin_valid;
          if (timer_inc == TMR_W'(TIMEOUT_CYC - 1)) begin
            state_d        = S_CHANGE;
            change_valid_d = 1'b1;
            change_amt_d   = credit_q;
          end else begin
            timer_d = timer_inc;
          end
        end
      end

      S_DISPENSE: begin
        coin_reject_d = coin_valid;
        if (bus.vend_ack) begin
          state_d        = S_CHANGE;
          vend_req_d     = 1'b0;
          vend_count_d   = vend_count_q + CNT_W'(1);
          change_valid_d = 1'b1;
        end
      end

      S_CHANGE: begin
        coin_reject_d = coin_valid;
        state_d       = S_IDLE;
        credit_d      = '0;
        product_sel_d = '0;
        change_amt_d  = '0;
        timer_d       = '0;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      product_sel_q  <= '0;
      credit_q       <= '0;
      timer_q        <= '0;
      vend_req_q     <= 1'b0;
      change_valid_q <= 1'b0;
      change_amt_q   <= '0;
      coin_reject_q  <= 1'b0;
      busy_q         <= 1'b0;
      vend_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      product_sel_q  <= product_sel_d;
      credit_q       <= credit_d;
      timer_q        <= timer_d;
      vend_req_q     <= vend_req_d;
      change_valid_q <= change_valid_d;
      change_amt_q   <= change_amt_d;
      coin_reject_q  <= coin_reject_d;
      busy_q         <= busy_d;
      vend_count_q   <= vend_count_d;
    end
  end

  assign bus.product_sel  = product_sel_q;
  assign bus.credit       = credit_q;
  assign bus.vend_req     = vend_req_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_amt   = change_amt_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.busy         = busy_q;
  assign bus.vend_count   = vend_count_q;

endmodule

// File: tb/tb_vending_fsm_param.sv
// Self-checking bench for vending_fsm_param: directed scenarios followed by
// random front-panel traffic, every cycle compared against a transaction-level
// model of the vending rules.
module tb_vending_fsm_param;

  localparam int TO = 16;

  logic clk;
  logic reset;

  vending_fsm_param_if #(.NUM_PROD(3), .NUM_COIN(3), .CREDIT_W(8), .CNT_W(16)) bus_if ();

  vending_fsm_param #(.TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int price_tab [3] = '{50, 75, 100};
  int coin_tab  [3] = '{25, 50, 100};

  int n_cmp = 0;
  int n_err = 0;

  // Model of the customer transaction.
  bit m_active;     // a transaction is open
  int m_prod;       // chosen product, -1 when none
  int m_credit;
  int m_idle;       // consecutive cycles without an accepted coin
  bit m_vending;    // waiting for the dispenser
  bit m_refunding;  // change is being paid out this cycle
  int m_change;
  int m_count;
  bit m_cv;
  bit m_rej;

  function automatic int lowest(input logic [2:0] v);
    for (int k = 0; k < 3; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_prod = -1; m_credit = 0; m_idle = 0;
    m_vending = 0; m_refunding = 0; m_change = 0; m_count = 0;
    m_cv = 0; m_rej = 0;
  endtask

  task automatic start_refund(input int amt);
    m_refunding = 1; m_cv = 1; m_change = amt;
  endtask

  task automatic model_step(input logic [2:0] s, input logic [2:0] c,
                            input logic cn, input logic a);
    int si, ci, v;
    si = lowest(s);
    ci = lowest(c);
    m_cv = 0;
    m_rej = 0;
    if (!m_active) begin
      if (si >= 0) begin
        m_active = 1; m_prod = si; m_credit = 0; m_idle = 0;
      end else if (ci >= 0) m_rej = 1;
    end else if (m_refunding) begin
      m_rej = (ci >= 0);
      m_active = 0; m_prod = -1; m_credit = 0; m_change = 0; m_refunding = 0;
    end else if (m_vending) begin
      m_rej = (ci >= 0);
      if (a) begin
        m_vending = 0;
        m_count = (m_count + 1) % 65536;
        start_refund(m_change);
      end
    end else begin
      if (cn) begin
        m_rej = (ci >= 0);
        start_refund(m_credit);
      end else if (ci >= 0 && m_credit + coin_tab[ci] <= 255) begin
        v = coin_tab[ci];
        m_credit += v;
        if (m_credit >= price_tab[m_prod]) begin
          m_vending = 1;
          m_change = m_credit - price_tab[m_prod];
        end else m_idle = 0;
      end else begin
        m_rej = (ci >= 0);
        m_idle++;
        if (m_idle == TO - 1) start_refund(m_credit);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".product_sel"}, 32'(bus_if.product_sel), (m_prod < 0) ? 32'd0 : (32'd1 << m_prod));
    check({tag, ".credit"},       32'(bus_if.credit),       32'(m_credit));
    check({tag, ".vend_req"},     32'(bus_if.vend_req),     32'(m_vending));
    check({tag, ".change_valid"}, 32'(bus_if.change_valid), 32'(m_cv));
    check({tag, ".change_amt"},   32'(bus_if.change_amt),   32'(m_change));
    check({tag, ".coin_reject"},  32'(bus_if.coin_reject),  32'(m_rej));
    check({tag, ".busy"},         32'(bus_if.busy),         32'(m_active));
    check({tag, ".vend_count"},   32'(bus_if.vend_count),   32'(m_count));
  endtask

  task automatic cycle(input logic [2:0] s, input logic [2:0] c, input logic cn,
                       input logic a, input string tag);
    bus_if.select   = s;
    bus_if.coin     = c;
    bus_if.cancel   = cn;
    bus_if.vend_ack = a;
    @(posedge clk);
    #1;
    model_step(s, c, cn, a);
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) cycle(3'b000, 3'b000, 1'b0, 1'b0, tag);
  endtask

  initial begin
    logic [2:0] rs, rc;
    logic       rcn, ra;

    reset = 1'b1;
    bus_if.select = '0; bus_if.coin = '0; bus_if.cancel = 1'b0; bus_if.vend_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // T1: product 0 (50) paid with two 25 coins, exact change.
    cycle(3'b001, 3'b000, 0, 0, "T1.sel");
    cycle(3'b000, 3'b001, 0, 0, "T1.coin1");
    check("T1.credit25", 32'(bus_if.credit), 32'd25);
    cycle(3'b000, 3'b001, 0, 0, "T1.coin2");
    check("T1.vend_req", 32'(bus_if.vend_req), 32'd1);
    idle(2, "T1.wait");
    cycle(3'b000, 3'b000, 0, 1, "T1.ack");
    check("T1.cv", 32'(bus_if.change_valid), 32'd1);
    check("T1.amt0", 32'(bus_if.change_amt), 32'd0);
    check("T1.count1", 32'(bus_if.vend_count), 32'd1);
    idle(1, "T1.end");

    // T2: product 1 (75) paid with 100, change 25.
    cycle(3'b010, 3'b000, 0, 0, "T2.sel");
    cycle(3'b000, 3'b100, 0, 0, "T2.coin");
    cycle(3'b000, 3'b000, 0, 1, "T2.ack");
    check("T2.amt25", 32'(bus_if.change_amt), 32'd25);
    idle(1, "T2.end");

    // T3: cancel refunds the credit without a vend.
    cycle(3'b100, 3'b000, 0, 0, "T3.sel");
    cycle(3'b000, 3'b001, 0, 0, "T3.coin");
    cycle(3'b000, 3'b000, 1, 0, "T3.cancel");
    check("T3.amt25", 32'(bus_if.change_amt), 32'd25);
    check("T3.noreq", 32'(bus_if.vend_req), 32'd0);
    idle(1, "T3.end");

    // T4: inactivity refund, then a late coin restarting the timer.
    cycle(3'b001, 3'b000, 0, 0, "T4.sel");
    cycle(3'b000, 3'b001, 0, 0, "T4.coin");
    idle(TO - 2, "T4.idle");
    check("T4.not_yet", 32'(bus_if.change_valid), 32'd0);
    idle(1, "T4.timeout");
    check("T4.cv", 32'(bus_if.change_valid), 32'd1);
    check("T4.amt25", 32'(bus_if.change_amt), 32'd25);
    idle(1, "T4.end");
    cycle(3'b100, 3'b000, 0, 0, "T4b.sel");
    cycle(3'b000, 3'b001, 0, 0, "T4b.coin1");
    idle(TO - 3, "T4b.idle1");
    cycle(3'b000, 3'b001, 0, 0, "T4b.coin2");
    idle(TO - 2, "T4b.idle2");
    check("T4b.still_busy", 32'(bus_if.busy), 32'd1);
    idle(1, "T4b.timeout");
    check("T4b.amt50", 32'(bus_if.change_amt), 32'd50);
    idle(1, "T4b.end");

    // T5: coin rejection in IDLE, DISPENSE, CHANGE; coin + cancel together.
    cycle(3'b000, 3'b010, 0, 0, "T5.idle_coin");
    check("T5.rej_idle", 32'(bus_if.coin_reject), 32'd1);
    cycle(3'b001, 3'b000, 0, 0, "T5.sel");
    cycle(3'b000, 3'b010, 0, 0, "T5.pay");
    cycle(3'b000, 3'b001, 0, 0, "T5.disp_coin");
    check("T5.rej_disp", 32'(bus_if.coin_reject), 32'd1);
    check("T5.credit50", 32'(bus_if.credit), 32'd50);
    cycle(3'b000, 3'b000, 0, 1, "T5.ack");
    cycle(3'b000, 3'b001, 0, 0, "T5.chg_coin");
    check("T5.rej_chg", 32'(bus_if.coin_reject), 32'd1);
    cycle(3'b010, 3'b000, 0, 0, "T5.sel2");
    cycle(3'b000, 3'b001, 0, 0, "T5.coin");
    cycle(3'b000, 3'b010, 1, 0, "T5.coin_cancel");
    check("T5.rej_cancel", 32'(bus_if.coin_reject), 32'd1);
    check("T5.refund25", 32'(bus_if.change_amt), 32'd25);
    idle(1, "T5.end");

    // T6: asynchronous reset while the dispenser request is pending.
    cycle(3'b010, 3'b000, 0, 0, "T6.sel");
    cycle(3'b000, 3'b100, 0, 0, "T6.coin");
    check("T6.req", 32'(bus_if.vend_req), 32'd1);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all("T6.async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(3, "T6.after");

    // Random front-panel traffic.
    for (int n = 0; n < 3000; n++) begin
      rs  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      rc  = (rs == 3'b000 && $urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      rcn = ($urandom_range(0, 24) == 0);
      ra  = ($urandom_range(0, 3) == 0);
      cycle(rs, rc, rcn, ra, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
